// File: rtl/sdrc_req_chunker.sv
// Splits application requests into page-safe chunks of at most MAX_BL words,
// tracking each chunk's data beats and acknowledging the whole request once.
module sdrc_req_chunker #(
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int MAX_BL = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        cfg_colbits,
  input  logic              app_req,
  input  logic [APP_AW-1:0] app_req_addr,
  input  logic [APP_RW-1:0] app_req_len,
  input  logic              app_req_wr_n,
  input  logic              app_req_dma_last,
  output logic              app_req_ack,
  output logic              dn_req,
  output logic [APP_AW-1:0] dn_req_addr,
  output logic [APP_RW-1:0] dn_req_len,
  output logic              dn_req_wr_n,
  output logic              dn_req_dma_last,
  input  logic              dn_req_ack,
  input  logic              dn_wr_next,
  input  logic              dn_rd_valid
);

  localparam int BW = $clog2(MAX_BL + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [APP_AW-1:0] cur_addr_q, cur_addr_d;
  logic [APP_RW-1:0] rem_len_q, rem_len_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              wr_n_q, wr_n_d;
  logic              dma_last_q, dma_last_d;

  logic [11:0]       page;
  logic [11:0]       offset;
  logic [11:0]       room;
  logic [11:0]       chunk12;
  logic [APP_RW-1:0] chunk;
  logic              beat;

  // Chunk size is bounded by remaining length, burst limit and room left in the page
  always_comb begin
    page    = 12'd1 << (4'd8 + {2'b00, cfg_colbits});
    offset  = cur_addr_q[11:0] & (page - 12'd1);
    room    = page - offset;
    chunk12 = 12'(rem_len_q);
    if (chunk12 > 12'(MAX_BL)) chunk12 = 12'(MAX_BL);
    if (chunk12 > room)        chunk12 = room;
    chunk   = APP_RW'(chunk12);
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    beat_cnt_d = beat_cnt_q;
    wr_n_d     = wr_n_q;
    dma_last_d = dma_last_q;
    beat       = wr_n_q ? dn_rd_valid : dn_wr_next;
    unique case (state_q)
      IDLE: begin
        if (app_req) begin
          cur_addr_d = app_req_addr;
          rem_len_d  = app_req_len;
          wr_n_d     = app_req_wr_n;
          dma_last_d = app_req_dma_last;
          state_d    = (app_req_len != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (dn_req_ack) begin
          beat_cnt_d = BW'(chunk);
          cur_addr_d = cur_addr_q + APP_AW'(chunk);
          rem_len_d  = rem_len_q - chunk;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q - BW'(1);
          if (beat_cnt_q == BW'(1)) state_d = (rem_len_q == '0) ? DONE : ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_len_q  <= '0;
      beat_cnt_q <= '0;
      wr_n_q     <= 1'b0;
      dma_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      beat_cnt_q <= beat_cnt_d;
      wr_n_q     <= wr_n_d;
      dma_last_q <= dma_last_d;
    end
  end

  // Request fields are forced to zero outside ISSUE so idle outputs stay quiet
  assign dn_req          = (state_q == ISSUE);
  assign dn_req_addr     = dn_req ? cur_addr_q : '0;
  assign dn_req_len      = dn_req ? chunk : '0;
  assign dn_req_wr_n     = dn_req & wr_n_q;
  assign dn_req_dma_last = dn_req & dma_last_q & (chunk == rem_len_q);
  assign app_req_ack     = (state_q == DONE);

endmodule
